systolic_result_drain: RTL and testbench

SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

---
 rtl/systolic_result_drain.sv | 131 +++++++++++++
 tb/tb_systolic_result_drain.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_result_drain.sv
// systolic_result_drain
//   Waits a fixed latency after the systolic array is started. It then takes
//   one snapshot of the whole PE result bus and streams the words out, one per
//   handshake, in ascending k order (k = x*Y + y).
//
//   Ports
//     clk        single clock, rising edge
//     rst        synchronous reset, active low
//     start      one-cycle pulse, raised together with the array's on/sn
//     Data       X*Y*M result bus, word k = Data[k*M +: M]
//     out_data   current streamed word (0 when out_valid is low)
//     out_valid  out_data holds a valid word
//     out_ready  downstream accepts when out_valid && out_ready
//     out_last   high with the final word (k = X*Y-1)
//     busy       high whenever not IDLE
//     done       one-cycle pulse after the final word is accepted
//
//   Optional build macro: DRAIN_RELU_EN
//     When it is defined, each word is treated as a signed value and any
//     negative word is output as 0. Handshake and timing do not change.
module systolic_result_drain #(
  parameter int M   = 11,
  parameter int X   = 4,
  parameter int Y   = 25,
  parameter int L2  = 9,
  parameter int LAT = L2 + X + Y + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [X*Y*M-1:0] Data,
  output logic [M-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int N  = X * Y;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(LAT + 1);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_STREAM,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [N-1:0][M-1:0] snap_q;
  logic                capture;
  logic [M-1:0]        word;
  logic                hs;

  assign hs = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // The counter holds LAT-1 on the first WAIT cycle. Capture happens on
        // the cycle it reads 0, so LAT = 1 captures in the first WAIT cycle.
        if (cnt_q == '0) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = S_STREAM;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STREAM: begin
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        // start is deliberately ignored here; a new run must begin from IDLE
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      if (capture) snap_q <= Data;
    end
  end

  assign word = snap_q[idx_q];

  assign out_valid = (state_q == S_STREAM);
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

`ifdef DRAIN_RELU_EN
  assign out_data = (out_valid && !word[M-1]) ? word : '0;
`else
  assign out_data = out_valid ? word : '0;
`endif

endmodule

// File: tb/tb_systolic_result_drain.sv
module tb_systolic_result_drain;
  localparam int M   = 11;
  localparam int X   = 4;
  localparam int Y   = 25;
  localparam int L2  = 9;
  localparam int LAT = L2 + X + Y + 1;
  localparam int N   = X * Y;

  logic           clk = 1'b0;
  logic           rst, start, out_ready;
  logic [N*M-1:0] Data;
  logic [M-1:0]   out_data;
  logic           out_valid, out_last, busy, done;

  int total = 0;
  int bad   = 0;

  logic [M-1:0] dat [N];
  logic [M-1:0] got [N];

  typedef struct {
    int           k;
    logic [M-1:0] din;
    logic [M-1:0] dexp;
  } vec_t;
  vec_t tbl [6];

  always #5 clk = ~clk;

  systolic_result_drain #(.M(M), .X(X), .Y(Y), .L2(L2), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .Data(Data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  function automatic logic [M-1:0] expw(input logic [M-1:0] w);
`ifdef DRAIN_RELU_EN
    return w[M-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_data();
    for (int k = 0; k < N; k++) Data[k*M +: M] = dat[k];
  endtask

  // rmode: 0 ready always high, 1 ready pattern 1,0,0,1, 2 random ready.
  // Model: the bus value present at edge LAT (counted from the start edge)
  // is what gets streamed; one word per accepted handshake, then one done.
  task automatic run(input int rmode, input bit corrupt, input bit restart,
                     input int rst_at);
    int e    = 0;
    int widx = 0;
    int c    = 0;
    int post = 0;
    bit r;
    @(negedge clk);
    drive_data();
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    while (e < 2000) begin
      @(negedge clk);
      start = 1'b0;
      if (restart && (e == 10 || e == 50)) start = 1'b1;
      if (e < LAT - 1) begin
        chk("wait_valid", out_valid, 0);
        chk("wait_busy", busy, 1);
        chk("wait_done", done, 0);
      end else if (e == LAT - 1) begin
        // final WAIT cycle: the bus is captured at the next edge
        chk("wait_valid", out_valid, 0);
        chk("wait_busy", busy, 1);
      end else if (widx < N) begin
        if (corrupt && e == LAT) Data = '1;
        chk("valid", out_valid, 1);
        chk("data", out_data, expw(dat[widx]));
        chk("last", out_last, (widx == N - 1));
        chk("stream_done", done, 0);
        got[widx] = out_data;
        if (widx == rst_at) begin
          rst = 1'b0;
          @(posedge clk);
          @(negedge clk);
          rst = 1'b1;
          chk("rst_valid", out_valid, 0);
          chk("rst_busy", busy, 0);
          chk("rst_last", out_last, 0);
          chk("rst_data", out_data, 0);
          for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_nodone", done | out_valid, 0);
          end
          return;
        end
        case (rmode)
          0:       r = 1'b1;
          1:       r = (c % 4 == 0) || (c % 4 == 3);
          default: r = 1'($urandom_range(0, 1));
        endcase
        c++;
        out_ready = r;
        if (r) widx++;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        if (post == 0) begin
          chk("done", done, 1);
          chk("done_valid", out_valid, 0);
          chk("done_last", out_last, 0);
          if (restart) start = 1'b1;
        end else begin
          chk("idle_done", done, 0);
          chk("idle_busy", busy, 0);
          if (post == 2) return;
        end
        post++;
      end
      @(posedge clk);
      e++;
    end
    chk("timeout", 1, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; out_ready = 1'b0; Data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", out_valid, 0);
    chk("reset_last", out_last, 0);
    chk("reset_data", out_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    // start together with reset must lose to reset
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("reset_prio", busy, 0);
    rst = 1'b1;

    // ascending words, ready held high
    for (int k = 0; k < N; k++) dat[k] = M'(k);
    run(0, 0, 0, -1);

    // table of signed corner words
`ifdef DRAIN_RELU_EN
    tbl[0] = '{0,  11'h7FF, 11'h000};
    tbl[1] = '{1,  11'h3FF, 11'h3FF};
    tbl[2] = '{2,  11'h400, 11'h000};
    tbl[3] = '{3,  11'h000, 11'h000};
    tbl[4] = '{50, 11'h001, 11'h001};
    tbl[5] = '{99, 11'h7FE, 11'h000};
`else
    tbl[0] = '{0,  11'h7FF, 11'h7FF};
    tbl[1] = '{1,  11'h3FF, 11'h3FF};
    tbl[2] = '{2,  11'h400, 11'h400};
    tbl[3] = '{3,  11'h000, 11'h000};
    tbl[4] = '{50, 11'h001, 11'h001};
    tbl[5] = '{99, 11'h7FE, 11'h7FE};
`endif
    for (int k = 0; k < N; k++) dat[k] = M'(k);
    for (int i = 0; i < 6; i++) dat[tbl[i].k] = tbl[i].din;
    run(0, 0, 0, -1);
    for (int i = 0; i < 6; i++) chk("tbl_word", got[tbl[i].k], tbl[i].dexp);

    // random words, ready 1,0,0,1
    for (int k = 0; k < N; k++) dat[k] = M'($urandom);
    run(1, 0, 0, -1);

    // random words, random ready, bus trashed after capture
    for (int k = 0; k < N; k++) dat[k] = M'($urandom);
    run(2, 1, 0, -1);

    // start re-pulsed mid-run and during DONE
    for (int k = 0; k < N; k++) dat[k] = M'($urandom);
    run(0, 0, 1, -1);

    // reset at word 40, then a fresh full run
    for (int k = 0; k < N; k++) dat[k] = M'(k);
    run(0, 0, 0, 40);
    for (int k = 0; k < N; k++) dat[k] = M'($urandom);
    run(2, 0, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
